// File: rtl/note_pkg.sv
// Shared types, default geometry and counter helpers for the note scheduler.
package note_pkg;

    localparam int unsigned DEF_ROWS      = 480;
    localparam int unsigned DEF_JUDGE_ROW = 440;
    localparam int unsigned DEF_WIN       = 8;
    localparam int unsigned DEF_PERF_WIN  = 2;
    localparam int unsigned LANES         = 4;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [2:0] {IDLE, RUN, FETCH, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {NONE, PERFECT, GOOD} grade_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Add 0..4 events to a total, pinning at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [2:0]       n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-2){1'b0}}, n};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/lane_judge.sv
// One lane: scrolling occupancy track with judgement-window search,
// hit clear, grading and miss detection.
module lane_judge
    import note_pkg::*;
#(
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned JUDGE_ROW = DEF_JUDGE_ROW,
    parameter int unsigned WIN       = DEF_WIN,
    parameter int unsigned PERF_WIN  = DEF_PERF_WIN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_hit,
    input  logic            i_shift,
    input  logic            i_inj,
    output logic [ROWS-1:0] o_track,
    output grade_t          o_grade_c,
    output logic            o_miss_c,
    output logic            o_empty_c
);

    localparam int unsigned IW  = $clog2(ROWS);
    localparam int unsigned LO  = JUDGE_ROW - WIN;
    localparam int unsigned HI  = JUDGE_ROW + WIN;
    localparam int unsigned PLO = JUDGE_ROW - PERF_WIN;
    localparam int unsigned PHI = JUDGE_ROW + PERF_WIN;

    logic [ROWS-1:0] r_track;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [ROWS-1:0] w_cleared;
    logic [ROWS-1:0] w_shifted;

    // Ascending scan so the last hit found is the lowest-on-screen note
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int r = int'(LO); r <= int'(HI); r++) begin
            if (r_track[IW'(r)]) begin
                w_found = 1'b1;
                w_idx   = IW'(r);
            end
        end
    end

    always_comb begin
        w_cleared = r_track;
        o_grade_c = NONE;
        if (i_hit && w_found) begin
            w_cleared[w_idx] = 1'b0;
            o_grade_c = (w_idx >= IW'(PLO) && w_idx <= IW'(PHI)) ? PERFECT : GOOD;
        end
    end

    // Miss looks at the post-hit vector so a note hit this cycle never counts twice
    assign w_shifted = {w_cleared[ROWS-2:0], i_inj};
    assign o_miss_c  = i_shift & w_cleared[HI];
    assign o_empty_c = ~|w_shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_track <= '0;
        end else if (i_clear) begin
            r_track <= '0;
        end else if (i_shift) begin
            r_track <= w_shifted;
        end else begin
            r_track <= w_cleared;
        end
    end

    assign o_track = r_track;

endmodule

// File: rtl/note_scheduler.sv
// Rhythm-game note scheduler: fetches chart rows per scroll tick, scrolls four
// lane tracks, and grades key presses against the judgement line.
module note_scheduler
    import note_pkg::*;
#(
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned JUDGE_ROW = DEF_JUDGE_ROW,
    parameter int unsigned WIN       = DEF_WIN,
    parameter int unsigned PERF_WIN  = DEF_PERF_WIN,
    parameter int unsigned AW        = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pause,
    input  logic            tick,
    input  logic [AW-1:0]   chart_len,
    output logic [AW-1:0]   chart_addr,
    input  logic [3:0]      chart_data,
    input  logic [3:0]      hit_req,
    output logic [ROWS-1:0] track0,
    output logic [ROWS-1:0] track1,
    output logic [ROWS-1:0] track2,
    output logic [ROWS-1:0] track3,
    output logic [3:0]      hit_perfect,
    output logic [3:0]      hit_good,
    output logic [3:0]      miss,
    output logic [15:0]     perfect_cnt,
    output logic [15:0]     good_cnt,
    output logic [15:0]     miss_cnt,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [3:0]      r_perf;
    logic [3:0]      r_good;
    logic [3:0]      r_miss;
    logic [15:0]     r_pcnt;
    logic [15:0]     r_gcnt;
    logic [15:0]     r_mcnt;
    logic            r_busy;
    logic            r_done;
    logic            r_overrun;

    logic            w_hit_en;
    logic            w_shift;
    logic            w_more;
    logic [AW-1:0]   w_addr_nxt;
    logic [3:0]      w_inj;
    logic [3:0]      w_perf_c;
    logic [3:0]      w_good_c;
    logic [3:0]      w_miss_c;
    logic [3:0]      w_empty_c;
    logic [ROWS-1:0] w_track [LANES];
    grade_t          w_grade [LANES];

    assign w_hit_en   = (r_state == RUN || r_state == FETCH || r_state == SHIFT) & ~pause & ~start;
    assign w_shift    = (r_state == SHIFT) & ~start;
    assign w_more     = r_addr < chart_len;
    assign w_addr_nxt = w_more ? r_addr + AW'(1) : r_addr;
    assign w_inj      = chart_data & {4{w_more}};

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        lane_judge #(
            .ROWS      (ROWS),
            .JUDGE_ROW (JUDGE_ROW),
            .WIN       (WIN),
            .PERF_WIN  (PERF_WIN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_clear   (start),
            .i_hit     (hit_req[i] & w_hit_en),
            .i_shift   (w_shift),
            .i_inj     (w_inj[i]),
            .o_track   (w_track[i]),
            .o_grade_c (w_grade[i]),
            .o_miss_c  (w_miss_c[i]),
            .o_empty_c (w_empty_c[i])
        );
        assign w_perf_c[i] = (w_grade[i] == PERFECT);
        assign w_good_c[i] = (w_grade[i] == GOOD);
    end

    // Control FSM, chart address, result pulses and totals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_perf    <= '0;
            r_good    <= '0;
            r_miss    <= '0;
            r_pcnt    <= '0;
            r_gcnt    <= '0;
            r_mcnt    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (start) begin
            r_state   <= RUN;
            r_addr    <= '0;
            r_perf    <= '0;
            r_good    <= '0;
            r_miss    <= '0;
            r_pcnt    <= '0;
            r_gcnt    <= '0;
            r_mcnt    <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_perf <= w_perf_c;
            r_good <= w_good_c;
            r_miss <= w_miss_c;
            r_pcnt <= sat_add(r_pcnt, popcnt4(w_perf_c));
            r_gcnt <= sat_add(r_gcnt, popcnt4(w_good_c));
            r_mcnt <= sat_add(r_mcnt, popcnt4(w_miss_c));
            r_done <= 1'b0;
            if (tick && !pause && r_state != RUN) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (tick && !pause) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: r_state <= SHIFT;
                SHIFT: begin
                    r_addr <= w_addr_nxt;
                    if (w_addr_nxt >= chart_len && &w_empty_c) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign chart_addr  = r_addr;
    assign track0      = w_track[0];
    assign track1      = w_track[1];
    assign track2      = w_track[2];
    assign track3      = w_track[3];
    assign hit_perfect = r_perf;
    assign hit_good    = r_good;
    assign miss        = r_miss;
    assign perfect_cnt = r_pcnt;
    assign good_cnt    = r_gcnt;
    assign miss_cnt    = r_mcnt;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler: vector table, directed corner
// sequences and randomized play against a note-list reference model.
module tb_note_scheduler;

    localparam int ROWS = 480;
    localparam int JR   = 440;
    localparam int WIN  = 8;
    localparam int PW   = 2;
    localparam int AW   = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            pause;
    logic            tick;
    logic [AW-1:0]   chart_len;
    logic [AW-1:0]   chart_addr;
    logic [3:0]      chart_data;
    logic [3:0]      hit_req;
    logic [ROWS-1:0] track0, track1, track2, track3;
    logic [3:0]      hit_perfect, hit_good, miss;
    logic [15:0]     perfect_cnt, good_cnt, miss_cnt;
    logic            busy, done, overrun;

    note_scheduler #(
        .ROWS(ROWS), .JUDGE_ROW(JR), .WIN(WIN), .PERF_WIN(PW), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .tick(tick),
        .chart_len(chart_len), .chart_addr(chart_addr), .chart_data(chart_data),
        .hit_req(hit_req), .track0(track0), .track1(track1), .track2(track2),
        .track3(track3), .hit_perfect(hit_perfect), .hit_good(hit_good),
        .miss(miss), .perfect_cnt(perfect_cnt), .good_cnt(good_cnt),
        .miss_cnt(miss_cnt), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous chart ROM: data valid one cycle after the address
    logic [3:0] rom [0:4095];
    always @(posedge clk) chart_data <= rom[chart_addr];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [ROWS-1:0] got, input logic [ROWS-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: a list of live notes, each a lane and a screen row
    typedef struct { int lane; int row; } note_t;
    note_t mq[$];
    int m_len, m_addr, m_pcnt, m_gcnt, m_mcnt;
    bit m_done;

    function automatic void model_start(input int len);
        mq.delete();
        m_len = len; m_addr = 0;
        m_pcnt = 0; m_gcnt = 0; m_mcnt = 0;
        m_done = 1'b0;
    endfunction

    function automatic void model_hit(input logic [3:0] hm, output logic [3:0] ep, output logic [3:0] eg);
        int best, bk, d;
        ep = '0; eg = '0;
        if (m_done) return;
        for (int l = 0; l < 4; l++) begin
            if (hm[l[1:0]]) begin
                best = -1; bk = -1;
                foreach (mq[k]) begin
                    if (mq[k].lane == l && mq[k].row >= JR-WIN && mq[k].row <= JR+WIN && mq[k].row > best) begin
                        best = mq[k].row; bk = k;
                    end
                end
                if (bk >= 0) begin
                    d = (best > JR) ? best - JR : JR - best;
                    if (d <= PW) ep |= 4'(1) << l;
                    else         eg |= 4'(1) << l;
                    mq.delete(bk);
                end
            end
        end
        m_pcnt += $countones(ep);
        m_gcnt += $countones(eg);
    endfunction

    function automatic void model_tick(output logic [3:0] mv, output bit dn);
        note_t t;
        mv = '0;
        for (int k = mq.size() - 1; k >= 0; k--) begin
            t = mq[k];
            if (t.row == JR + WIN) mv |= 4'(1) << t.lane;
            t.row++;
            if (t.row >= ROWS) mq.delete(k);
            else mq[k] = t;
        end
        if (m_addr < m_len) begin
            for (int l = 0; l < 4; l++) begin
                if (rom[12'(m_addr)][l[1:0]]) begin
                    t.lane = l; t.row = 0;
                    mq.push_back(t);
                end
            end
            m_addr++;
        end
        m_mcnt += $countones(mv);
        dn = (m_addr >= m_len) && (mq.size() == 0);
        m_done = dn;
    endfunction

    function automatic logic [ROWS-1:0] exp_track(input int lane);
        logic [ROWS-1:0] v;
        v = '0;
        foreach (mq[k]) if (mq[k].lane == lane) v |= ROWS'(1) << mq[k].row;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ep, input logic [3:0] eg,
                             input logic [3:0] em, input bit dn);
        chk({tag, " hit_perfect"}, ROWS'(hit_perfect), ROWS'(ep));
        chk({tag, " hit_good"}, ROWS'(hit_good), ROWS'(eg));
        chk({tag, " miss"}, ROWS'(miss), ROWS'(em));
        chk({tag, " track0"}, track0, exp_track(0));
        chk({tag, " track1"}, track1, exp_track(1));
        chk({tag, " track2"}, track2, exp_track(2));
        chk({tag, " track3"}, track3, exp_track(3));
        chk({tag, " perfect_cnt"}, ROWS'(perfect_cnt), ROWS'(16'(m_pcnt)));
        chk({tag, " good_cnt"}, ROWS'(good_cnt), ROWS'(16'(m_gcnt)));
        chk({tag, " miss_cnt"}, ROWS'(miss_cnt), ROWS'(16'(m_mcnt)));
        chk({tag, " done"}, ROWS'(done), ROWS'(dn));
        chk({tag, " busy"}, ROWS'(busy), ROWS'(!m_done));
    endtask

    task automatic do_start(input int len);
        chart_len = AW'(len);
        start = 1'b1; cyc(); start = 1'b0;
        model_start(len);
    endtask

    // One accepted tick: RUN -> FETCH -> SHIFT -> RUN, hs pressed in the SHIFT cycle
    task automatic tick_seq(input logic [3:0] hs, input bit full, output bit saw_done);
        logic [3:0] ep, eg, em;
        bit dn;
        model_hit(hs, ep, eg);
        model_tick(em, dn);
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        hit_req = hs; cyc(); hit_req = '0;
        saw_done = done;
        if (full) check_all("tick", ep, eg, em, dn);
    endtask

    task automatic ticks(input int n);
        bit d;
        for (int k = 0; k < n; k++) tick_seq(4'b0, 1'b0, d);
    endtask

    task automatic hit_run(input logic [3:0] hm, output logic [3:0] ep, output logic [3:0] eg);
        model_hit(hm, ep, eg);
        hit_req = hm; cyc(); hit_req = '0;
    endtask

    task automatic run_to_done(input string tag);
        bit seen, d;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            tick_seq(4'b0, 1'b0, d);
            seen = d;
        end
        chk({tag, " done seen"}, ROWS'(seen), ROWS'(1'b1));
    endtask

    typedef struct {
        int         n;
        logic [3:0] notes;
        logic [3:0] hit;
        logic [3:0] e_perf;
        logic [3:0] e_good;
        int         e_miss;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [3:0] ep, eg;
        logic [ROWS-1:0] saved;
        bit d;

        vt[0] = '{441, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0};
        vt[1] = '{447, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0};
        vt[2] = '{443, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0};
        vt[3] = '{444, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 0};
        vt[4] = '{433, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 0};
        vt[5] = '{432, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1};
        vt[6] = '{449, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 1};
        vt[7] = '{450, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1};
        vt[8] = '{441, 4'b1111, 4'b0101, 4'b0101, 4'b0000, 2};
        vt[9] = '{439, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0};

        for (int a = 0; a < 4096; a++) rom[a] = '0;
        rst = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0;
        hit_req = '0; chart_len = '0;
        model_start(0);
        cyc(); cyc();
        chk("reset chart_addr", ROWS'(chart_addr), '0);
        chk("reset track0", track0, '0);
        chk("reset counters", ROWS'({perfect_cnt, good_cnt, miss_cnt}), '0);
        chk("reset pulses", ROWS'({hit_perfect, hit_good, miss}), '0);
        chk("reset flags", ROWS'({busy, done, overrun}), '0);
        rst = 1'b0; cyc();

        // Vector table: one note row, a hit after n ticks, then play out
        for (int v = 0; v < 10; v++) begin
            rom[0] = vt[v].notes;
            do_start(1);
            ticks(vt[v].n);
            hit_run(vt[v].hit, ep, eg);
            chk($sformatf("vec%0d hit_perfect", v), ROWS'(hit_perfect), ROWS'(vt[v].e_perf));
            chk($sformatf("vec%0d hit_good", v), ROWS'(hit_good), ROWS'(vt[v].e_good));
            chk($sformatf("vec%0d perfect_cnt", v), ROWS'(perfect_cnt), ROWS'(16'($countones(vt[v].e_perf))));
            chk($sformatf("vec%0d good_cnt", v), ROWS'(good_cnt), ROWS'(16'($countones(vt[v].e_good))));
            run_to_done($sformatf("vec%0d", v));
            chk($sformatf("vec%0d miss_cnt", v), ROWS'(miss_cnt), ROWS'(16'(vt[v].e_miss)));
            chk($sformatf("vec%0d tracks", v), track0 | track1 | track2 | track3, '0);
            chk($sformatf("vec%0d busy", v), ROWS'(busy), '0);
        end

        // Unhit note: miss exactly on the tick leaving row 448, done after row 479
        rom[0] = 4'b0001;
        do_start(1);
        ticks(448);
        tick_seq(4'b0, 1'b0, d);
        chk("miss early", ROWS'(miss), '0);
        tick_seq(4'b0, 1'b0, d);
        chk("miss pulse", ROWS'(miss), ROWS'(4'b0001));
        chk("miss_cnt one", ROWS'(miss_cnt), ROWS'(16'd1));
        ticks(30);
        chk("row 479 track0", track0, ROWS'(1) << 479);
        chk("not done yet", ROWS'({done, busy}), ROWS'(2'b01));
        tick_seq(4'b0, 1'b0, d);
        chk("done at exit", ROWS'({done, busy}), ROWS'(2'b10));
        chk("track0 exited", track0, '0);
        cyc();
        chk("done one cycle", ROWS'(done), '0);

        // All lanes hit at row 440 in the SHIFT cycle
        rom[0] = 4'b1111;
        do_start(1);
        ticks(441);
        tick_seq(4'b1111, 1'b1, d);
        chk("quad perfect_cnt", ROWS'(perfect_cnt), ROWS'(16'd4));
        chk("quad tracks zero", track0 | track1 | track2 | track3, '0);

        // Tick during FETCH sets overrun; a restart while busy clears it
        for (int a = 0; a < 3; a++) rom[a] = 4'(a + 5);
        do_start(3);
        tick = 1'b1; cyc();
        chk("overrun before", ROWS'(overrun), '0);
        cyc(); tick = 1'b0; cyc();
        begin
            logic [3:0] em;
            bit dn;
            model_tick(em, dn);
        end
        chk("overrun set", ROWS'(overrun), ROWS'(1'b1));
        chk("overrun single shift", track0 | (track2 << 1), exp_track(0) | (exp_track(2) << 1));
        chk("overrun addr", ROWS'(chart_addr), ROWS'(12'd1));
        do_start(3);
        chk("restart clears", ROWS'({overrun, busy, chart_addr}), ROWS'({1'b0, 1'b1, 12'd0}));
        chk("restart tracks", track0 | track1 | track2 | track3, '0);
        ticks(3);
        saved = track0 | (track1 << 1);
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick = 1'b1; hit_req = 4'b1111; cyc(); tick = 1'b0; hit_req = '0; cyc(); cyc();
        end
        pause = 1'b0;
        chk("pause tracks", track0 | (track1 << 1), saved);
        chk("pause model", track2, exp_track(2));
        chk("pause quiet", ROWS'({overrun, chart_addr}), ROWS'({1'b0, 12'd3}));

        // Asynchronous reset mid-chart with a note at row 300
        rom[0] = 4'b0001;
        do_start(1);
        ticks(301);
        chk("pre-reset row 300", track0, ROWS'(1) << 300);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("async reset tracks", track0 | track1 | track2 | track3, '0);
        chk("async reset outputs", ROWS'({chart_addr, perfect_cnt, good_cnt, miss_cnt,
             hit_perfect, hit_good, miss, busy, done, overrun}), '0);
        #10; rst = 1'b0; cyc();

        // Randomized play against the note-list model
        for (int c = 0; c < 3; c++) begin
            int len, iter;
            len = int'($urandom_range(20, 60));
            for (int a = 0; a < len; a++) rom[a] = 4'($urandom);
            do_start(len);
            iter = 0;
            while (!m_done && iter < 1500) begin
                iter++;
                case ($urandom_range(0, 5))
                    0, 1: begin
                        hit_run(4'($urandom), ep, eg);
                        check_all("rnd hit", ep, eg, 4'b0, 1'b0);
                    end
                    2: begin
                        pause = 1'b1; tick = 1'b1; hit_req = 4'($urandom);
                        cyc();
                        pause = 1'b0; tick = 1'b0; hit_req = '0;
                        check_all("rnd pause", 4'b0, 4'b0, 4'b0, 1'b0);
                        cyc(); cyc();
                    end
                    default: tick_seq(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0, 1'b1, d);
                endcase
            end
            chk("rnd finished", ROWS'(m_done), ROWS'(1'b1));
            chk("rnd overrun", ROWS'(overrun), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
